// File: rtl/uart_txr.sv
`default_nettype none
// ============================================================================
// Module   : uart_txr
// Purpose  : UART transmitter. 1 start bit (low), 8 data bits MSB first,
//            1 stop bit (high), fixed CLKS_PER_BIT clocks per bit.
//            One byte per valid/ready handshake; accepted only in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module uart_txr #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_line,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  // Clock counter runs 0..CLKS_PER_BIT-1 inside every bit period.
  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q,  line_d;
  logic          done_q,  done_d;

  logic          w_bit_end;

  assign w_bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers; reset forces the line high immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the next line level is computed here so the line
  // itself always comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        cnt_d  = '0;
        bit_d  = '0;
        if (i_tx_valid) begin
          state_d = S_START;
          shift_d = i_tx_byte;
          line_d  = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          line_d  = shift_q[7];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            line_d  = 1'b1;
          end else begin
            // Next bit to send is the one just below the current MSB.
            shift_d = {shift_q[6:0], 1'b0};
            line_d  = shift_q[6];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        line_d = 1'b1;
        if (w_bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        line_d  = 1'b1;
      end
    endcase
  end

  assign o_tx_ready = (state_q == S_IDLE);
  assign o_tx_busy  = ~o_tx_ready;
  assign o_tx_line  = line_q;
  assign o_tx_done  = done_q;

endmodule
`default_nettype wire
